// File: rtl/bcd_to_binary_seq_pkg.sv
// Shared constants, FSM state type and digit helper for the sequential
// BCD-to-binary converter.
package bcd_to_binary_seq_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_MAX     = 9;
  localparam int ADJ_THRESH  = 8;
  localparam int ADJ_SUB     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] digit);
    return digit > BCD_DIGIT_W'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_to_binary_seq_digit_adjust.sv
// Per-digit correction for reverse double-dabble: after a right shift, any
// digit that picked up a weight-8 bit from its upper neighbour is reduced by 3.
module bcd_digit_adjust
  import bcd_to_binary_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted
);

  always_comb begin
    adjusted = digit;
    if (digit >= BCD_DIGIT_W'(ADJ_THRESH)) begin
      adjusted = digit - BCD_DIGIT_W'(ADJ_SUB);
    end
  end

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter: one reverse double-dabble shift per
// clock, start/done handshake, error flag for non-decimal digits.
module bcd_to_binary_seq
  import bcd_to_binary_seq_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                          busy,
  output logic                          done,
  output logic [BIN_W-1:0]              bin_out,
  output logic                          err
);

  localparam int BCD_W  = BCD_DIGIT_W * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);

  state_t            state;
  state_t            state_next;
  logic [WORK_W-1:0] work;
  logic [WORK_W-1:0] shifted;
  logic [BCD_W-1:0]  adj_bcd;
  logic [CNT_W-1:0]  cnt;
  logic              bad_digit;
  logic              last_shift;

  // Work register layout: {bcd field, bin field}; bits fall from bcd into bin.
  assign shifted    = work >> 1;
  assign last_shift = (cnt == LAST_SHIFT);

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit    (shifted[BIN_W + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .adjusted (adj_bcd[BCD_DIGIT_W*g +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_invalid(bcd_in[BCD_DIGIT_W*i +: BCD_DIGIT_W])) begin
        bad_digit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = bad_digit ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (last_shift) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Datapath: bcd_in is captured only on acceptance; results update only on
  // the transition into DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work    <= '0;
      cnt     <= '0;
      bin_out <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (bad_digit) begin
              bin_out <= '0;
              err     <= 1'b1;
            end else begin
              work <= {bcd_in, {BIN_W{1'b0}}};
              cnt  <= '0;
            end
          end
        end
        SHIFT: begin
          work <= {adj_bcd, shifted[BIN_W-1:0]};
          cnt  <= cnt + CNT_W'(1);
          if (last_shift) begin
            bin_out <= shifted[BIN_W-1:0];
            err     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: directed table, handshake and
// reset corner cases, exhaustive 0..255 and random vectors against a model.
module tb_bcd_to_binary_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] bcd_in;
  logic        busy;
  logic        done;
  logic [9:0]  bin_out;
  logic        err;

  int checks;
  int errors;

  bcd_to_binary_seq #(.DIGITS(3), .BIN_W(10)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] bcd;
    int          bin;
    bit          e;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decimal value of a packed 3-digit BCD word; zero with error if any digit > 9.
  function automatic void model(input logic [11:0] b, output int v, output bit e);
    int d;
    v = 0;
    e = 0;
    for (int i = 2; i >= 0; i--) begin
      d = int'((b >> (4*i)) & 12'hF);
      if (d > 9) e = 1;
      v = v * 10 + d;
    end
    if (e) v = 0;
  endfunction

  function automatic logic [11:0] to_bcd(input int n);
    return 12'(((n / 100) << 8) | (((n / 10) % 10) << 4) | (n % 10));
  endfunction

  // Starts a conversion at the next edge (cycle 0), returns the result and the
  // cycle in which done was seen (0 on timeout). Also checks outputs hold and
  // busy stays high until done, and that done lasts exactly one cycle.
  task automatic run_conv(input logic [11:0] bcd, input string name,
                          output int bin, output bit e, output int lat);
    logic [9:0] prev;
    bit         stable;
    prev   = bin_out;
    stable = 1;
    lat    = 0;
    start  = 1'b1;
    bcd_in = bcd;
    tick();
    start  = 1'b0;
    bcd_in = 12'($urandom);
    for (int k = 1; k <= 40; k++) begin
      if (!busy) stable = 0;
      if (done) begin
        lat = k;
        break;
      end
      if (bin_out !== prev) stable = 0;
      tick();
    end
    bin = int'(bin_out);
    e   = err;
    check({name, " hold/busy"}, stable, 1);
    tick();
    check({name, " done pulse width"}, {done, busy}, 0);
  endtask

  vec_t tbl[10];
  int   bin;
  bit   e;
  int   lat;
  int   exp_bin;
  bit   exp_e;
  int   n_done;
  bit   busy_ok;

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    bcd_in = '0;

    tbl[0] = '{12'h999, 999, 0};
    tbl[1] = '{12'h000,   0, 0};
    tbl[2] = '{12'h255, 255, 0};
    tbl[3] = '{12'h1A3,   0, 1};
    tbl[4] = '{12'h042,  42, 0};
    tbl[5] = '{12'h0F0,   0, 1};
    tbl[6] = '{12'hA00,   0, 1};
    tbl[7] = '{12'h009,   9, 0};
    tbl[8] = '{12'h500, 500, 0};
    tbl[9] = '{12'h998, 998, 0};

    tick();
    tick();
    check("reset outputs", {busy, done, err, bin_out}, 0);
    rst = 1'b0;
    tick();

    foreach (tbl[i]) begin
      run_conv(tbl[i].bcd, $sformatf("tbl%0d", i), bin, e, lat);
      check($sformatf("tbl%0d bin_out", i), bin, tbl[i].bin);
      check($sformatf("tbl%0d err", i), e, tbl[i].e);
      check($sformatf("tbl%0d latency", i), lat, tbl[i].e ? 1 : 11);
    end

    // start held high with changing bcd_in throughout the conversion
    n_done  = 0;
    busy_ok = 1;
    lat     = 0;
    start   = 1'b1;
    bcd_in  = 12'h321;
    tick();
    for (int k = 1; k <= 14; k++) begin
      if (busy !== (k <= 11)) busy_ok = 0;
      if (done) begin
        n_done++;
        lat   = k;
        bin   = int'(bin_out);
        start = 1'b0;
      end
      bcd_in = to_bcd(int'($urandom_range(0, 999)));
      tick();
    end
    start = 1'b0;
    check("restart done count", n_done, 1);
    check("restart latency", lat, 11);
    check("restart bin_out", bin, 321);
    check("restart busy window", busy_ok, 1);

    // reset in cycle 5 of a conversion
    start  = 1'b1;
    bcd_in = 12'h456;
    tick();
    start = 1'b0;
    for (int k = 1; k < 5; k++) tick();
    check("pre-reset busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid reset outputs", {busy, done, err, bin_out}, 0);
    n_done = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done) n_done++;
    end
    rst = 1'b0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (done) n_done++;
    end
    check("no done after reset", n_done, 0);
    run_conv(12'h128, "post reset", bin, e, lat);
    check("post reset bin_out", bin, 128);
    check("post reset err", e, 0);

    // exhaustive 0..255 via binary-to-BCD conversion
    for (int n = 0; n < 256; n++) begin
      run_conv(to_bcd(n), $sformatf("exh%0d", n), bin, e, lat);
      check($sformatf("exh%0d bin_out", n), bin, n);
      check($sformatf("exh%0d err", n), e, 0);
    end

    // random words, roughly half with a non-decimal digit
    for (int i = 0; i < 60; i++) begin
      logic [11:0] r;
      r = (i % 2 == 0) ? to_bcd(int'($urandom_range(0, 999))) : 12'($urandom);
      model(r, exp_bin, exp_e);
      run_conv(r, $sformatf("rnd%0d", i), bin, e, lat);
      check($sformatf("rnd%0d bin_out (bcd %03h)", i, r), bin, exp_bin);
      check($sformatf("rnd%0d err (bcd %03h)", i, r), e, exp_e);
      check($sformatf("rnd%0d latency", i), lat, exp_e ? 1 : 11);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
